// File: rtl/jtkunio_gfx_pkg.sv
// Shared types for the Kunio graphics ROM arbiter.
//  client_t : identifies one of the three graphics ROM clients
//  state_t  : arbiter FSM states
//  next_client() gives the round-robin successor of a client.
package jtkunio_gfx_pkg;

  typedef enum logic [1:0] {
    CH_CHAR = 2'd0,
    CH_SCR  = 2'd1,
    CH_OBJ  = 2'd2
  } client_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  // Widest client address (object ROM); the latched tag uses this width
  localparam int TAGW = 18;

  function automatic client_t next_client(input client_t c);
    case (c)
      CH_CHAR: return CH_SCR;
      CH_SCR:  return CH_OBJ;
      default: return CH_CHAR;
    endcase
  endfunction

endpackage

// File: rtl/jtkunio_gfxrom_slot.sv
// One-word buffer for a single graphics ROM client.
// Holds the tag, valid flag and data word; ok is a zero-latency hit flag.
//  clk, rst_n : clock and synchronous active-low reset
//  cs, addr   : client select and current word address
//  wr         : load wr_tag/wr_data into the buffer and mark it valid
//  data, ok   : buffered word and hit indication
module jtkunio_gfxrom_slot
  import jtkunio_gfx_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  output logic [31:0]   data,
  output logic          ok
);

  logic [AW-1:0] tag;
  logic          valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag   <= '0;
      valid <= 1'b0;
      data  <= '0;
    end else if (wr) begin
      tag   <= wr_tag;
      valid <= 1'b1;
      data  <= wr_data;
    end
  end

  // A deselected client never reports a hit, even with a valid buffer
  assign ok = cs & valid & (addr == tag);

endmodule

// File: rtl/jtkunio_gfxrom_arb.sv
// Shares one SDRAM read port between the char, scroll and object ROM clients.
// Each client has a one-word tagged buffer; misses are served round-robin with
// a single outstanding SDRAM read.
//  clk, rst_n        : clock and synchronous active-low reset
//  char_/scr_/obj_*  : per-client cs, word address, buffered data and ok flag
//  sdram_req/addr    : read request (held until ack) and SDRAM word address
//  sdram_ack         : request accepted pulse
//  sdram_dst/data    : read data valid pulse and data word
module jtkunio_gfxrom_arb
  import jtkunio_gfx_pkg::*;
#(
  parameter int                SDRAMW      = 22,
  parameter logic [SDRAMW-1:0] CHAR_OFFSET = 22'h00000,
  parameter logic [SDRAMW-1:0] SCR_OFFSET  = 22'h04000,
  parameter logic [SDRAMW-1:0] OBJ_OFFSET  = 22'h24000,
  parameter int                TIMEOUT     = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              char_cs,
  input  logic [13:0]       char_addr,
  output logic [31:0]       char_data,
  output logic              char_ok,
  input  logic              scr_cs,
  input  logic [16:0]       scr_addr,
  output logic [31:0]       scr_data,
  output logic              scr_ok,
  input  logic              obj_cs,
  input  logic [17:0]       obj_addr,
  output logic [31:0]       obj_data,
  output logic              obj_ok,
  output logic              sdram_req,
  output logic [SDRAMW-1:0] sdram_addr,
  input  logic              sdram_ack,
  input  logic              sdram_dst,
  input  logic [31:0]       sdram_data
);

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

  state_t            state, state_nxt;
  client_t           gnt, gnt_nxt;
  client_t           rr, rr_nxt;
  client_t           pick;
  logic [5:0]        cnt, cnt_nxt;
  logic              req, req_nxt;
  logic [SDRAMW-1:0] addr_q, addr_nxt;
  logic [TAGW-1:0]   lat, lat_nxt;
  logic [TAGW-1:0]   sel_tag;
  logic [SDRAMW-1:0] sel_off;
  logic [2:0]        pend;
  logic              wr;

  assign pend = {obj_cs & ~obj_ok, scr_cs & ~scr_ok, char_cs & ~char_ok};

  // rr is the first client to consider; fall through to its successors
  always_comb begin
    pick = rr;
    if (!pend[rr]) begin
      pick = next_client(rr);
      if (!pend[pick]) pick = next_client(pick);
    end
  end

  always_comb begin
    sel_tag = '0;
    sel_off = CHAR_OFFSET;
    case (pick)
      CH_CHAR: begin
        sel_tag = {4'd0, char_addr};
        sel_off = CHAR_OFFSET;
      end
      CH_SCR: begin
        sel_tag = {1'b0, scr_addr};
        sel_off = SCR_OFFSET;
      end
      default: begin
        sel_tag = obj_addr;
        sel_off = OBJ_OFFSET;
      end
    endcase
  end

  // Next-state logic. The rr pointer moves past the granted client when its
  // read finishes, whether by data or by timeout.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr;
    cnt_nxt   = cnt;
    req_nxt   = req;
    addr_nxt  = addr_q;
    lat_nxt   = lat;
    wr        = 1'b0;
    case (state)
      IDLE: begin
        if (|pend) begin
          gnt_nxt   = pick;
          lat_nxt   = sel_tag;
          addr_nxt  = sel_off + SDRAMW'(sel_tag);
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_nxt = 1'b0;
          if (sdram_dst) begin
            wr        = 1'b1;
            rr_nxt    = next_client(gnt);
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = '0;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (sdram_dst) begin
          wr        = 1'b1;
          rr_nxt    = next_client(gnt);
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          rr_nxt    = next_client(gnt);
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt    <= CH_CHAR;
      rr     <= CH_CHAR;
      cnt    <= '0;
      req    <= 1'b0;
      addr_q <= '0;
      lat    <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      rr     <= rr_nxt;
      cnt    <= cnt_nxt;
      req    <= req_nxt;
      addr_q <= addr_nxt;
      lat    <= lat_nxt;
    end
  end

  assign sdram_req  = req;
  assign sdram_addr = addr_q;

  jtkunio_gfxrom_slot #(.AW(14)) u_char (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (char_cs),
    .addr    (char_addr),
    .wr      (wr && gnt == CH_CHAR),
    .wr_tag  (lat[13:0]),
    .wr_data (sdram_data),
    .data    (char_data),
    .ok      (char_ok)
  );

  jtkunio_gfxrom_slot #(.AW(17)) u_scr (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (scr_cs),
    .addr    (scr_addr),
    .wr      (wr && gnt == CH_SCR),
    .wr_tag  (lat[16:0]),
    .wr_data (sdram_data),
    .data    (scr_data),
    .ok      (scr_ok)
  );

  jtkunio_gfxrom_slot #(.AW(18)) u_obj (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (obj_cs),
    .addr    (obj_addr),
    .wr      (wr && gnt == CH_OBJ),
    .wr_tag  (lat),
    .wr_data (sdram_data),
    .data    (obj_data),
    .ok      (obj_ok)
  );

endmodule
